// File: rtl/execute_exception_sequencer.sv
`timescale 1ns/1ps
// Execute-stage exception/IRQ event sequencer: picks an exception or IRQ, latches its vector,
// then walks HOLD -> START -> F2B -> B2F -> END and presents the vector on END.
module execute_exception_sequencer #(
  parameter int P_DRAIN_CYCLES = 2,
  parameter int P_WAIT_TIMEOUT = 255
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iRESET_SYNC,
  input  logic        iEXCEPT_VALID,
  input  logic [6:0]  iEXCEPT_NUM,
  input  logic [31:0] iEXCEPT_FI0R,
  input  logic [31:0] iEXCEPT_FI1R,
  input  logic        iIRQ_REQ,
  input  logic [6:0]  iIRQ_NUM,
  input  logic        iIRQ_ENABLE,
  input  logic        iFRONT2BACK_DONE,
  input  logic        iBACK2FRONT_DONE,
  output logic        oEVENT_HOLD,
  output logic        oEVENT_START,
  output logic        oEVENT_IRQ_FRONT2BACK,
  output logic        oEVENT_IRQ_BACK2FRONT,
  output logic        oEVENT_END,
  output logic        oIRQ_ACK,
  output logic        oINT_VALID,
  output logic [6:0]  oINT_NUM,
  output logic [31:0] oINT_FI0R,
  output logic [31:0] oINT_FI1R,
  output logic        oBUSY,
  output logic        oTIMEOUT
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_F2B, S_B2F, S_END} state_t;

  typedef struct packed {
    logic [6:0]  num;
    logic [31:0] fi0;
    logic [31:0] fi1;
  } vec_t;

  localparam logic [7:0] DRAIN_LAST = 8'(P_DRAIN_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(P_WAIT_TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       src_irq_q;
  vec_t       vec_q;
  logic       hold_q, start_q, f2b_q, b2f_q, end_q, ack_q, busy_q, timeout_q;

  // One counter serves both the drain count in HOLD and the handshake wait in F2B/B2F.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      src_irq_q <= 1'b0;
      vec_q     <= '0;
      {hold_q, start_q, f2b_q, b2f_q, end_q, ack_q, busy_q, timeout_q} <= '0;
    end else if (iRESET_SYNC) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      src_irq_q <= 1'b0;
      vec_q     <= '0;
      {hold_q, start_q, f2b_q, b2f_q, end_q, ack_q, busy_q, timeout_q} <= '0;
    end else begin
      hold_q  <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      ack_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iEXCEPT_VALID || (iIRQ_REQ && iIRQ_ENABLE)) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            hold_q    <= 1'b1;
            busy_q    <= 1'b1;
            src_irq_q <= !iEXCEPT_VALID;
            if (iEXCEPT_VALID) vec_q <= vec_t'{iEXCEPT_NUM, iEXCEPT_FI0R, iEXCEPT_FI1R};
            else               vec_q <= vec_t'{iIRQ_NUM, 32'h0, 32'h0};
          end
        end
        S_HOLD: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= S_START;
            start_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_START: begin
          state_q <= S_F2B;
          f2b_q   <= 1'b1;
          cnt_q   <= '0;
        end
        S_F2B: begin
          if (iFRONT2BACK_DONE) begin
            state_q <= S_B2F;
            f2b_q   <= 1'b0;
            b2f_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (cnt_q == WAIT_LAST) begin
            state_q   <= S_END;
            f2b_q     <= 1'b0;
            timeout_q <= 1'b1;
            end_q     <= 1'b1;
            ack_q     <= src_irq_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_B2F: begin
          if (iBACK2FRONT_DONE || (cnt_q == WAIT_LAST)) begin
            state_q <= S_END;
            b2f_q   <= 1'b0;
            end_q   <= 1'b1;
            ack_q   <= src_irq_q;
            if (!iBACK2FRONT_DONE) timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_END: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oEVENT_HOLD           = hold_q;
  assign oEVENT_START          = start_q;
  assign oEVENT_IRQ_FRONT2BACK = f2b_q;
  assign oEVENT_IRQ_BACK2FRONT = b2f_q;
  assign oEVENT_END            = end_q;
  assign oINT_VALID            = end_q;
  assign oIRQ_ACK              = ack_q;
  assign oBUSY                 = busy_q;
  assign oTIMEOUT              = timeout_q;
  assign oINT_NUM              = vec_q.num;
  assign oINT_FI0R             = vec_q.fi0;
  assign oINT_FI1R             = vec_q.fi1;

endmodule
